// File: rtl/pwm_pkg.sv
// Shared definitions for the sine/PWM chain: controller state encoding and
// the default sample and carrier geometry used by sine_top, pwm and sine_pwm_ctrl.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PEND  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int         DEF_WIDTH       = 12;
   localparam int         DEF_CARR_W      = 8;
   localparam logic [7:0] DEF_CARRIER_MAX = 8'hff;

endpackage

// File: rtl/sine_pwm_ctrl_sw_debounce.sv
// Frequency-select switch conditioning: a two-flop synchronizer followed by a
// stability counter. The accepted level changes only after the synchronized
// input has disagreed with it for DEBOUNCE_CYC consecutive cycles.
module sw_debounce #(
   parameter int DEBOUNCE_CYC = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic sw_db
);

   localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] stab;

   // Synchronize the raw switch and count consecutive cycles of disagreement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         stab  <= '0;
         sw_db <= 1'b0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         if (sync2 != sw_db) begin
            if (stab == CW'(DEBOUNCE_CYC - 1)) begin
               sw_db <= sync2;
               stab  <= '0;
            end else begin
               stab <= stab + CW'(1);
            end
         end else begin
            // Any bounce back to the accepted level restarts the count.
            stab <= '0;
         end
      end
   end

endmodule

// File: rtl/sine_pwm_ctrl.sv
// Sequencer between the sine generator and the PWM modulator. Owns the
// carrier counter, latches duty only at carrier wrap, issues the sample
// advance tick, and defers frequency changes to a sine period boundary.
module sine_pwm_ctrl
   import pwm_pkg::*;
#(
   parameter int                WIDTH        = DEF_WIDTH,
   parameter int                CARR_W       = DEF_CARR_W,
   parameter logic [CARR_W-1:0] CARRIER_MAX  = CARR_W'(DEF_CARRIER_MAX),
   parameter int                TICK_DIV     = 1,
   parameter int                DEBOUNCE_CYC = 50000,
   parameter int                PEND_TIMEOUT = 1000000
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              en_in,
   input  logic              sw_in,
   input  logic [WIDTH-1:0]  sine_in,
   input  logic              phase_wrap_in,
   output logic              freq_sel_out,
   output logic              sample_tick_out,
   output logic [WIDTH-1:0]  duty_out,
   output logic [CARR_W-1:0] carrier_cnt_out,
   output logic              carrier_sync_out,
   output logic              pending_out
);

   localparam int TW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV + 1);
   localparam int PW = (PEND_TIMEOUT < 2) ? 1 : $clog2(PEND_TIMEOUT + 1);

   // Carrier advance with wrap at the terminal count.
   function automatic logic [CARR_W-1:0] carrier_step(input logic [CARR_W-1:0] c);
      return (c == CARRIER_MAX) ? '0 : c + CARR_W'(1);
   endfunction

   logic sw_db;

   state_t            state,  state_nx;
   logic [CARR_W-1:0] cnt,    cnt_nx;
   logic [WIDTH-1:0]  duty,   duty_nx;
   logic              fsel,   fsel_nx;
   logic              tick,   tick_nx;
   logic              sync,   sync_nx;
   logic              pend,   pend_nx;
   logic [TW-1:0]     tdiv,   tdiv_nx;
   logic [TW-1:0]     tdiv_base;
   logic [PW-1:0]     tout,   tout_nx;
   logic              carr_wrap;
   logic [CARR_W-1:0] carr_inc;

   sw_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_sw_debounce (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .sw    (sw_in),
      .sw_db (sw_db)
   );

   // Next-state and next-output decode; every output is registered from these.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      duty_nx   = duty;
      fsel_nx   = fsel;
      tdiv_base = tdiv;
      tout_nx   = '0;
      carr_wrap = (cnt == CARRIER_MAX);
      carr_inc  = carrier_step(cnt);

      case (state)
         IDLE: begin
            // Generator is stopped, so the select may track the switch freely.
            cnt_nx    = '0;
            duty_nx   = '0;
            fsel_nx   = sw_db;
            tdiv_base = '0;
            if (en_in) begin
               state_nx = RUN;
               duty_nx  = sine_in;
            end
         end
         RUN, PEND: begin
            cnt_nx = carr_inc;
            if (carr_wrap) begin
               duty_nx = sine_in;
            end
            if (!en_in) begin
               state_nx = DRAIN;
            end else if (state == PEND) begin
               if (phase_wrap_in || (tout == PW'(PEND_TIMEOUT - 1))) begin
                  fsel_nx  = sw_db;
                  state_nx = RUN;
               end else if (sw_db == fsel) begin
                  state_nx = RUN;
               end else begin
                  tout_nx = tout + PW'(1);
               end
            end else if (sw_db != fsel) begin
               // A wrap seen in this same cycle does not count; wait for the next.
               state_nx = PEND;
            end
         end
         DRAIN: begin
            if (en_in) begin
               state_nx = RUN;
               cnt_nx   = carr_inc;
               if (carr_wrap) begin
                  duty_nx = sine_in;
               end
            end else if (carr_wrap) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               duty_nx  = '0;
            end else begin
               cnt_nx = carr_inc;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      sync_nx = (state_nx != IDLE) && (cnt_nx == '0);
      pend_nx = (state_nx == PEND);

      // The first sync after leaving IDLE counts as one towards the divider.
      tick_nx = 1'b0;
      tdiv_nx = tdiv_base;
      if (sync_nx) begin
         if (tdiv_base == TW'(TICK_DIV - 1)) begin
            tick_nx = 1'b1;
            tdiv_nx = '0;
         end else begin
            tdiv_nx = tdiv_base + TW'(1);
         end
      end
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
         cnt   <= '0;
         duty  <= '0;
         fsel  <= 1'b0;
         tick  <= 1'b0;
         sync  <= 1'b0;
         pend  <= 1'b0;
         tdiv  <= '0;
         tout  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         duty  <= duty_nx;
         fsel  <= fsel_nx;
         tick  <= tick_nx;
         sync  <= sync_nx;
         pend  <= pend_nx;
         tdiv  <= tdiv_nx;
         tout  <= tout_nx;
      end
   end

   assign freq_sel_out     = fsel;
   assign sample_tick_out  = tick;
   assign duty_out         = duty;
   assign carrier_cnt_out  = cnt;
   assign carrier_sync_out = sync;
   assign pending_out      = pend;

endmodule
